// File: rtl/vga_pkg.sv
// Shared timing defaults, error-bit map, monitor FSM states and signature helpers
// for the vga_monitor checker.
package vga_pkg;

    localparam int unsigned H_TOTAL_DEF  = 800;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned V_TOTAL_DEF  = 525;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_SYNC_DEF   = 2;

    localparam int unsigned ERR_HTOT = 0;
    localparam int unsigned ERR_HSW  = 1;
    localparam int unsigned ERR_HACT = 2;
    localparam int unsigned ERR_VTOT = 3;
    localparam int unsigned ERR_VSW  = 4;
    localparam int unsigned ERR_VACT = 5;
    localparam int unsigned ERR_W    = 6;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } mon_state_t;

    // MSB-first CRC-32 over one 24-bit RGB word.
    function automatic logic [31:0] crc32_step24(input logic [31:0] crc, input logic [23:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 24; i++) begin
            if (c[31] ^ data[23 - i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else                      c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_mon_sig.sv
// Active-pixel signature register. VGA_MON_CRC_EN selects CRC-32, otherwise
// a rotate-left/XOR accumulator.
module vga_mon_sig
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    input  logic [23:0] data,
    output logic [31:0] sig
);

`ifdef VGA_MON_CRC_EN
    localparam logic [31:0] SIG_INIT = '1;
`else
    localparam logic [31:0] SIG_INIT = '0;
`endif

    logic [31:0] sig_next;

    always_comb begin
`ifdef VGA_MON_CRC_EN
        sig_next = crc32_step24(sig, data);
`else
        sig_next = {sig[30:0], sig[31]} ^ {8'h00, data};
`endif
    end

    always_ff @(posedge clk) begin
        if (clear)       sig <= SIG_INIT;
        else if (enable) sig <= sig_next;
    end

endmodule

// File: rtl/vga_monitor.sv
// Checks the VGA_* pin bundle against 640x480@60 geometry; reports per-frame
// errors, lock, frame count and active-pixel signature (VGA_MON_CRC_EN: CRC-32).
module vga_monitor
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    output logic        locked,
    output logic        frame_done,
    output logic [5:0]  frame_err,
    output logic [5:0]  sticky_err,
    output logic [15:0] frame_count,
    output logic [31:0] frame_sig
);

    localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
    localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYN_L = 11'(H_SYNC);
    localparam logic [9:0]  V_TOT_L = 10'(V_TOTAL);
    localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYN_L = 10'(V_SYNC);

    logic        vga_clk_q, hs_q, vs_q;
    logic        pix_en, hs_fall, hs_rise, vs_fall;
    logic [10:0] h_cnt, hs_low, h_act;
    logic [9:0]  v_cnt, v_act, vs_lines;
    logic [9:0]  v_cnt_cl, v_act_cl, vs_lines_cl;
    logic [5:0]  err_acc, line_err, frame_err_nxt;
    logic        good_cnt, good_cnt_nxt, frame_close, clean;
    logic [31:0] sig;
    mon_state_t  state, state_nxt;

    assign pix_en  = VGA_CLK & ~vga_clk_q;
    assign hs_fall = pix_en & hs_q & ~VGA_HS;
    assign hs_rise = pix_en & ~hs_q & VGA_HS;
    assign vs_fall = pix_en & vs_q & ~VGA_VS;

    // Closing-frame vertical values include a line whose HS fall coincides with the VS fall.
    always_comb begin
        line_err = '0;
        if (hs_fall && h_cnt != H_TOT_L)                  line_err[ERR_HTOT] = 1'b1;
        if (hs_fall && h_act != '0 && h_act != H_ACT_L)   line_err[ERR_HACT] = 1'b1;
        if (hs_rise && hs_low != H_SYN_L)                 line_err[ERR_HSW]  = 1'b1;

        v_cnt_cl    = v_cnt + {9'd0, hs_fall};
        v_act_cl    = v_act + {9'd0, hs_fall && h_act != '0};
        vs_lines_cl = vs_lines + {9'd0, hs_fall && !VGA_VS};

        frame_err_nxt = err_acc | line_err;
        if (v_cnt_cl != V_TOT_L)    frame_err_nxt[ERR_VTOT] = 1'b1;
        if (vs_lines_cl != V_SYN_L) frame_err_nxt[ERR_VSW]  = 1'b1;
        if (v_act_cl != V_ACT_L)    frame_err_nxt[ERR_VACT] = 1'b1;
        clean = (frame_err_nxt == '0);
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        frame_close  = 1'b0;
        if (vs_fall) begin
            unique case (state)
                SEARCH: begin
                    state_nxt    = MEASURE;
                    good_cnt_nxt = 1'b0;
                end
                MEASURE: begin
                    frame_close = 1'b1;
                    if (!clean)        good_cnt_nxt = 1'b0;
                    else if (good_cnt) state_nxt    = LOCKED;
                    else               good_cnt_nxt = 1'b1;
                end
                LOCKED: begin
                    frame_close = 1'b1;
                    if (!clean) begin
                        state_nxt    = MEASURE;
                        good_cnt_nxt = 1'b0;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vga_clk_q   <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            h_cnt       <= '0;
            hs_low      <= '0;
            h_act       <= '0;
            v_cnt       <= '0;
            v_act       <= '0;
            vs_lines    <= '0;
            err_acc     <= '0;
            state       <= SEARCH;
            good_cnt    <= 1'b0;
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= '0;
            sticky_err  <= '0;
            frame_count <= '0;
            frame_sig   <= '0;
        end else begin
            vga_clk_q  <= VGA_CLK;
            state      <= state_nxt;
            good_cnt   <= good_cnt_nxt;
            frame_done <= frame_close;
            locked     <= (state_nxt == LOCKED);
            if (frame_close) begin
                frame_err   <= frame_err_nxt;
                frame_sig   <= sig;
                sticky_err  <= sticky_err | frame_err_nxt;
                frame_count <= frame_count + 16'd1;
            end
            if (pix_en) begin
                hs_q   <= VGA_HS;
                vs_q   <= VGA_VS;
                h_cnt  <= hs_fall ? 11'd1 : h_cnt + 11'd1;
                hs_low <= VGA_HS ? '0 : hs_low + 11'd1;
                h_act  <= (hs_fall ? '0 : h_act) + {10'd0, VGA_BLANK_N};
                if (vs_fall) begin
                    v_cnt    <= '0;
                    v_act    <= '0;
                    vs_lines <= '0;
                    err_acc  <= '0;
                end else begin
                    v_cnt    <= v_cnt_cl;
                    v_act    <= v_act_cl;
                    vs_lines <= vs_lines_cl;
                    if (state != SEARCH) err_acc <= err_acc | line_err;
                end
            end
        end
    end

    vga_mon_sig u_sig (
        .clk    (CLOCK_50),
        .clear  (reset | vs_fall),
        .enable (pix_en & VGA_BLANK_N),
        .data   ({VGA_R, VGA_G, VGA_B}),
        .sig    (sig)
    );

endmodule

// File: tb/tb_vga_monitor.sv
// Directed bench for vga_monitor on a scaled-down 20x12 raster.
module tb_vga_monitor;

    localparam int unsigned HT = 20, HA = 12, HSW = 3, HS_START = 14;
    localparam int unsigned VT = 12, VA = 8, VSW = 2, VS_START = 9;

`ifdef VGA_MON_CRC_EN
    localparam logic [31:0] SIG0 = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SIG0 = 32'h0;
`endif

    typedef enum int {M_CLEAN, M_HS_SHORT, M_SHORT_ACT, M_SHORT_FRAME, M_ZERO, M_ONEPIX, M_RESET_MID} mode_t;

    logic        CLOCK_50 = 1'b0, reset = 1'b1, VGA_CLK = 1'b0;
    logic        VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK_N = 1'b0;
    logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic        locked, frame_done;
    logic [5:0]  frame_err, sticky_err;
    logic [15:0] frame_count;
    logic [31:0] frame_sig;

    vga_monitor #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC(VSW)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .locked(locked), .frame_done(frame_done), .frame_err(frame_err),
        .sticky_err(sticky_err), .frame_count(frame_count), .frame_sig(frame_sig)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int tests_run = 0, tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          done_cnt = 0;
    logic [5:0]  cap_err, cap_sticky;
    logic [31:0] cap_sig;
    logic        cap_locked;
    logic [15:0] cap_count;

    always @(negedge CLOCK_50) begin
        if (frame_done === 1'b1) begin
            done_cnt++;
            cap_err    = frame_err;
            cap_sticky = sticky_err;
            cap_sig    = frame_sig;
            cap_locked = locked;
            cap_count  = frame_count;
        end
    end

    function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [23:0] d);
`ifdef VGA_MON_CRC_EN
        logic [31:0] c;
        c = s;
        for (int unsigned i = 0; i < 24; i++)
            c = (c[31] ^ d[23 - i]) ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        return c;
`else
        return {s[30:0], s[31]} ^ {8'h00, d};
`endif
    endfunction

    logic [31:0] exp_sig;
    int unsigned frame_no = 0;

    task automatic drive_pixel(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
        @(negedge CLOCK_50);
        VGA_HS = hs; VGA_VS = vs; VGA_BLANK_N = blank;
        {VGA_R, VGA_G, VGA_B} = rgb;
        VGA_CLK = 1'b1;
        @(negedge CLOCK_50);
        VGA_CLK = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".locked"}, 32'(locked), 32'h0);
        check({tag, ".done"},   32'(frame_done), 32'h0);
        check({tag, ".err"},    32'(frame_err), 32'h0);
        check({tag, ".sticky"}, 32'(sticky_err), 32'h0);
        check({tag, ".count"},  32'(frame_count), 32'h0);
        check({tag, ".sig"},    frame_sig, 32'h0);
    endtask

    // The frame_done for a driven frame's active lines fires at its own VS fall (line VS_START).
    task automatic drive_frame(input mode_t mode, input int exp_done, input logic [5:0] exp_err,
                               input logic exp_lock, input logic [15:0] exp_count,
                               input logic [5:0] exp_sticky, input string tag);
        int          done_before;
        logic        hs, vs, blank;
        logic [23:0] rgb;
        done_before = 0;
        exp_sig = SIG0;
        frame_no++;
        for (int unsigned y = 0; y < VT; y++) begin
            if (mode == M_SHORT_FRAME && y == 8) continue;
            if (y == VS_START) done_before = done_cnt;
            for (int unsigned x = 0; x < HT; x++) begin
                if (mode == M_RESET_MID && y == 3 && x == 5) begin
                    @(negedge CLOCK_50) reset = 1'b1;
                    @(negedge CLOCK_50) reset = 1'b0;
                    check_idle_outputs({tag, ".rst"});
                end
                blank = (y < VA && x < HA);
                if (mode == M_SHORT_ACT && y == 4 && x == HA - 1) blank = 1'b0;
                hs = !(x >= HS_START && x < HS_START + HSW);
                if (mode == M_HS_SHORT && y == 2 && x == HS_START + HSW - 1) hs = 1'b1;
                vs = !(y >= VS_START && y < VS_START + VSW);
                case (mode)
                    M_ZERO:   rgb = '0;
                    M_ONEPIX: rgb = (y == VA - 1 && x == HA - 1) ? 24'h000001 : 24'h0;
                    default:  rgb = {8'(x * 9 + y), 8'(y * 17), 8'(x ^ y ^ frame_no)};
                endcase
                if (!blank) rgb = '0;
                else        exp_sig = sig_step(exp_sig, rgb);
                drive_pixel(hs, vs, blank, rgb);
            end
            if (y == VS_START) begin
                check({tag, ".ndone"}, 32'(done_cnt - done_before), 32'(exp_done));
                if (exp_done != 0) begin
                    check({tag, ".err"},    32'(cap_err), 32'(exp_err));
                    check({tag, ".locked"}, 32'(cap_locked), 32'(exp_lock));
                    check({tag, ".count"},  32'(cap_count), 32'(exp_count));
                    check({tag, ".sticky"}, 32'(cap_sticky), 32'(exp_sticky));
                    check({tag, ".sig"},    cap_sig, exp_sig);
                end
            end
        end
    endtask

    initial begin
        int done_snap;
        repeat (4) @(negedge CLOCK_50);
        check_idle_outputs("reset");
        reset = 1'b0;

        drive_frame(M_CLEAN, 0, 6'h00, 1'b0, 16'd0, 6'h00, "f1_search");
        drive_frame(M_CLEAN, 1, 6'h00, 1'b0, 16'd1, 6'h00, "f2_clean");
        drive_frame(M_CLEAN, 1, 6'h00, 1'b1, 16'd2, 6'h00, "f3_lock");

        drive_frame(M_HS_SHORT, 1, 6'b000010, 1'b0, 16'd3, 6'b000010, "f4_hsw");
        drive_frame(M_CLEAN,    1, 6'h00,     1'b0, 16'd4, 6'b000010, "f5_clean");
        drive_frame(M_CLEAN,    1, 6'h00,     1'b1, 16'd5, 6'b000010, "f6_relock");

        drive_frame(M_SHORT_ACT, 1, 6'b000100, 1'b0, 16'd6, 6'b000110, "f7_hact");
        drive_frame(M_CLEAN,     1, 6'h00,     1'b0, 16'd7, 6'b000110, "f8_clean");
        drive_frame(M_CLEAN,     1, 6'h00,     1'b1, 16'd8, 6'b000110, "f9_relock");

        drive_frame(M_SHORT_FRAME, 1, 6'b001000, 1'b0, 16'd9,  6'b001110, "f10_vtot");
        drive_frame(M_CLEAN,       1, 6'h00,     1'b0, 16'd10, 6'b001110, "f11_good1");
        drive_frame(M_CLEAN,       1, 6'h00,     1'b1, 16'd11, 6'b001110, "f12_relock");

        drive_frame(M_ZERO, 1, 6'h00, 1'b1, 16'd12, 6'b001110, "f13_zero");
`ifndef VGA_MON_CRC_EN
        check("f13_zero.sig_const", cap_sig, 32'h0);
`endif
        drive_frame(M_ONEPIX, 1, 6'h00, 1'b1, 16'd13, 6'b001110, "f14_onepix");
`ifndef VGA_MON_CRC_EN
        check("f14_onepix.sig_const", cap_sig, 32'h1);
`endif

        // Pixel clock held low while sync lines thrash: nothing may move.
        done_snap = done_cnt;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge CLOCK_50);
            VGA_HS = i[0]; VGA_VS = i[1]; VGA_BLANK_N = i[2];
        end
        @(negedge CLOCK_50);
        VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;
        check("noclk.count",  32'(frame_count), 32'd13);
        check("noclk.locked", 32'(locked), 32'h1);
        check("noclk.ndone",  32'(done_cnt - done_snap), 32'h0);

        drive_frame(M_CLEAN,     1, 6'h00, 1'b1, 16'd14, 6'b001110, "f15_clean");
        drive_frame(M_RESET_MID, 0, 6'h00, 1'b0, 16'd0,  6'h00,     "f16_rstmid");
        drive_frame(M_CLEAN,     1, 6'h00, 1'b0, 16'd1,  6'h00,     "f17_clean");
        drive_frame(M_CLEAN,     1, 6'h00, 1'b1, 16'd2,  6'h00,     "f18_lock");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_monitor.md
Name: vga_monitor

Overview:
Synthesizable downstream checker that consumes the VGA_* pin bundle produced by the vga block, in the same CLOCK_50 domain.
- Recovers pixel strobes from VGA_CLK.
- Measures horizontal/vertical sync and blanking geometry against 640x480@60 parameters.
- Produces per-frame pass/fail flags, a lock indication, a frame counter and an active-pixel signature.
- Used in vga_tb as a self-checking scoreboard and on-board for SignalTap/LED debug.

Parameters:
H_TOTAL, 800, pixel clocks per line (HS fall to HS fall)
H_ACTIVE, 640, pixels per line with VGA_BLANK_N high
H_SYNC, 96, pixels HS held low
V_TOTAL, 525, lines per frame (VS fall to VS fall)
V_ACTIVE, 480, lines containing active pixels
V_SYNC, 2, HS falls counted while VS low

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
VGA_CLK  in  1  pixel clock from vga (CLOCK_50/2)
VGA_HS  in  1  horizontal sync, active low
VGA_VS  in  1  vertical sync, active low
VGA_BLANK_N  in  1  high = active pixel
VGA_R  in  8  red
VGA_G  in  8  green
VGA_B  in  8  blue
locked  out  1  two consecutive clean frames seen
frame_done  out  1  one-cycle pulse at each checked frame boundary
frame_err  out  6  per-frame error bits, valid with frame_done
sticky_err  out  6  OR of all frame_err since reset
frame_count  out  16  checked frames, wraps 0xFFFF->0
frame_sig  out  32  signature of previous frame's active RGB, valid with frame_done

Behaviour:
- Reset: all outputs 0, counters 0, FSM=SEARCH, edge registers cleared. Applies identically mid-frame.
- Pixel strobe: pix_en = VGA_CLK & ~vga_clk_q (vga_clk_q is a registered copy of VGA_CLK).
  - All VGA_* inputs sampled only on pix_en; previous-sample registers hs_q/vs_q are updated on pix_en.
  - hs_fall = hs_q & ~VGA_HS; hs_rise = ~hs_q & VGA_HS; vs_fall analogous.
- Horizontal, per pix_en:
  - h_cnt (11b) increments; reset to 1 on hs_fall.
  - hs_low counts pixels while HS low; checked on hs_rise.
  - h_act counts BLANK_N high.
  - On hs_fall, line checks use pre-reset values:
    - err[0] if h_cnt != H_TOTAL.
    - err[2] if h_act not in {0, H_ACTIVE}.
- HS width: on hs_rise, err[1] if hs_low != H_SYNC.
- Vertical:
  - v_cnt increments on hs_fall.
  - v_act increments on hs_fall when h_act != 0.
  - vs_lines counts hs_fall while VS low.
  - On vs_fall: err[3] if v_cnt != V_TOTAL; err[4] if vs_lines != V_SYNC; err[5] if v_act != V_ACTIVE. Then all vertical counters clear.
  - Simultaneous hs_fall and vs_fall: the line is counted into the closing frame first, then counters clear.
- Error accumulator: an internal 6-bit register collects line and HS-width errors during a frame; cleared at vs_fall.
- FSM:
  - SEARCH: ignore all checks; on vs_fall -> MEASURE.
  - MEASURE: on vs_fall, evaluate. If clean, -> LOCKED when a previous clean frame was seen (good_cnt=1), else good_cnt=1. On error, good_cnt=0 and stay.
  - LOCKED: on any frame error -> MEASURE, locked=0.
  - Exit from SEARCH produces no frame_done (partial frame).
- Outputs:
  - frame_done, frame_err and frame_sig are registered one CLOCK_50 cycle after the pix_en carrying vs_fall.
  - frame_count increments with frame_done.
  - locked is registered, high only in LOCKED.
- Signature: when BLANK_N high, sig <= rotl(sig,1) ^ {8'h00,R,G,B}. Cleared at vs_fall after capture into frame_sig.
- Missing VGA_CLK: no pix_en, state frozen, no outputs change.

Optional Feature:
VGA_MON_CRC_EN
- Defined: the signature is CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, 24-bit RGB word per pixel, no final XOR).
- Undefined: the rotate-XOR signature above.
- Ports and timing are identical either way.

Decomposition:
- Package vga_pkg: timing constants (H_TOTAL etc. defaults), error bit index localparams (ERR_HTOT=0, ERR_HSW=1, ERR_HACT=2, ERR_VTOT=3, ERR_VSW=4, ERR_VACT=5), FSM enum mon_state_t {SEARCH, MEASURE, LOCKED}, CRC polynomial constant.
- One sub-module: vga_mon_sig (signature update, ifdef-selected), with clear/enable/data in and sig out.

Test Plan:
- Ideal 640x480 stimulus from vga, 3 frames -> first vs_fall gives no pulse; frame_done #1 err=0 locked=0; frame_done #2 err=0 locked=1; frame_count=2.
- HS low 95 pixels on one line -> that frame's frame_err=6'b000010, locked drops to 0, sticky_err[1]=1, relocks after 2 clean frames.
- One line with 639 active pixels -> frame_err[2]=1 and frame_err[5]=0 (line still counted active).
- Frame of 524 lines -> frame_err=6'b001000; next clean frame with good_cnt=1 does not lock until the following one.
- Constant RGB 0x000000 over whole frame -> frame_sig=0 (no-CRC build); CRC build gives the reference-model value; a single pixel change alters frame_sig.
- reset asserted mid-frame for 1 cycle -> all outputs 0, FSM=SEARCH, next vs_fall produces no frame_done.
